fizzbuzz_sequencer: RTL and testbench

Run controller for the FIZZ/BUZZ period-counter datapath. It holds the run-time configuration (fizz period, buzz period, sequence length) and sequences the counters through one run on start. It emits one classified event per index on a valid/ready stream and supports pause and abort. It sits between a host config port and any downstream consumer of the fizz/buzz/fizzbuzz stream.

---
 rtl/fizzbuzz_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fizzbuzz_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fizzbuzz_sequencer.sv
// Run controller for the FIZZ/BUZZ period counters: holds run config, emits one
// classified event per index on a valid/ready stream. Optional stats: FIZZBUZZ_SEQ_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for start, config writable
// RUN    | presenting a beat, waiting for handshake
// PAUSE  | next beat held, waiting for pause release
// DONE   | last beat accepted, config writable
module fizzbuzz_sequencer #(
    parameter int W        = 8,
    parameter int DEF_FIZZ = 3,
    parameter int DEF_BUZZ = 5,
    parameter int DEF_MAX  = 100
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_fizz,
    input  logic [W-1:0] cfg_buzz,
    input  logic [W-1:0] cfg_max,
    output logic         cfg_ready,
    output logic         cfg_err,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_code,
    output logic [W-1:0] out_index,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] stat_fizz,
    output logic [W-1:0] stat_buzz,
    output logic [W-1:0] stat_fb
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [W-1:0] DEF_FIZZ_V = W'(DEF_FIZZ);
    localparam logic [W-1:0] DEF_BUZZ_V = W'(DEF_BUZZ);
    localparam logic [W-1:0] DEF_MAX_V  = W'(DEF_MAX);

    state_t       state, state_nxt;
    logic [W-1:0] fizz_q, buzz_q, max_q;
    logic [W-1:0] ph_fizz, ph_buzz, ph_fizz_nxt, ph_buzz_nxt;
    logic         cfg_acc, cfg_bad, cfg_load, hs, last_beat, run_start;

    always_comb begin
        cfg_acc     = cfg_valid & cfg_ready;
        cfg_bad     = (cfg_fizz == '0) | (cfg_buzz == '0) | (cfg_max == '0);
        cfg_load    = cfg_acc & ~cfg_bad;
        hs          = (state == S_RUN) & out_valid & out_ready;
        last_beat   = (out_index == max_q - 1'b1);
        run_start   = ~abort & start & cfg_ready;
        // Phase counters replace a divider: each wraps at its period.
        ph_fizz_nxt = (ph_fizz == fizz_q - 1'b1) ? '0 : ph_fizz + 1'b1;
        ph_buzz_nxt = (ph_buzz == buzz_q - 1'b1) ? '0 : ph_buzz + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_RUN;
                S_RUN: begin
                    if (hs) begin
                        if (last_beat)  state_nxt = S_DONE;
                        else if (pause) state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: if (!pause) state_nxt = S_RUN;
                S_DONE: begin
                    if (start)        state_nxt = S_RUN;
                    else if (cfg_acc) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready = (state == S_IDLE) || (state == S_DONE);
        busy      = (state == S_RUN) || (state == S_PAUSE);
        done      = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fizz_q    <= DEF_FIZZ_V;
            buzz_q    <= DEF_BUZZ_V;
            max_q     <= DEF_MAX_V;
            ph_fizz   <= '0;
            ph_buzz   <= '0;
            out_valid <= 1'b0;
            out_code  <= 2'd0;
            out_index <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_acc & cfg_bad;
            if (cfg_load) begin
                fizz_q <= cfg_fizz;
                buzz_q <= cfg_buzz;
                max_q  <= cfg_max;
            end
            if (abort) begin
                out_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            out_valid <= 1'b1;
                            out_index <= '0;
                            out_code  <= 2'd3;
                            ph_fizz   <= '0;
                            ph_buzz   <= '0;
                        end
                    end
                    S_RUN: begin
                        if (hs) begin
                            if (last_beat) begin
                                out_valid <= 1'b0;
                            end else begin
                                // Payload advances even when pausing; PAUSE holds the next beat.
                                out_index <= out_index + 1'b1;
                                ph_fizz   <= ph_fizz_nxt;
                                ph_buzz   <= ph_buzz_nxt;
                                out_code  <= {ph_buzz_nxt == '0, ph_fizz_nxt == '0};
                                out_valid <= ~pause;
                            end
                        end
                    end
                    S_PAUSE: if (!pause) out_valid <= 1'b1;
                    default: out_valid <= 1'b0;
                endcase
            end
        end
    end

`ifdef FIZZBUZZ_SEQ_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_fizz <= '0;
            stat_buzz <= '0;
            stat_fb   <= '0;
        end else if (run_start) begin
            stat_fizz <= '0;
            stat_buzz <= '0;
            stat_fb   <= '0;
        end else if (hs && !abort) begin
            case (out_code)
                2'd1: if (stat_fizz != '1) stat_fizz <= stat_fizz + 1'b1;
                2'd2: if (stat_buzz != '1) stat_buzz <= stat_buzz + 1'b1;
                2'd3: if (stat_fb != '1)   stat_fb   <= stat_fb + 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign stat_fizz = '0;
    assign stat_buzz = '0;
    assign stat_fb   = '0;
    logic unused_stats;
    assign unused_stats = run_start;
`endif

endmodule

// File: tb/tb_fizzbuzz_sequencer.sv
// Bench for fizzbuzz_sequencer: directed scenarios plus random traffic, all checked
// each cycle against a modulo-arithmetic model of the run protocol.
module tb_fizzbuzz_sequencer;
    localparam int W = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic         clk = 1'b0, resetn = 1'b0;
    logic         cfg_valid = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [W-1:0] cfg_fizz = '0, cfg_buzz = '0, cfg_max = '0;
    logic         cfg_ready, cfg_err, out_valid, busy, done;
    logic [1:0]   out_code;
    logic [W-1:0] out_index, stat_fizz, stat_buzz, stat_fb;

    always #5 clk = ~clk;

    fizzbuzz_sequencer #(.W(W)) dut (
        .clk(clk), .resetn(resetn),
        .cfg_valid(cfg_valid), .cfg_fizz(cfg_fizz), .cfg_buzz(cfg_buzz), .cfg_max(cfg_max),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .start(start), .pause(pause), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_index(out_index),
        .busy(busy), .done(done),
        .stat_fizz(stat_fizz), .stat_buzz(stat_buzz), .stat_fb(stat_fb)
    );

    int n_checks = 0, n_errors = 0;
    bit chk_en = 1'b0;
    int got_codes[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int code_of(input int i, input int f, input int b);
        return ((i % b) == 0 ? 2 : 0) + ((i % f) == 0 ? 1 : 0);
    endfunction

    // Reference model: spec states, modulo classification, no phase counters.
    int m_st, m_fizz, m_buzz, m_max, m_idx, m_sf, m_sb, m_sfb;
    bit m_valid, m_err, m_acc, m_bad, m_hs;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_st = M_IDLE; m_fizz = 3; m_buzz = 5; m_max = 100; m_idx = 0;
            m_valid = 0; m_err = 0; m_sf = 0; m_sb = 0; m_sfb = 0;
        end else begin
            m_acc = cfg_valid && (m_st == M_IDLE || m_st == M_DONE);
            m_bad = m_acc && (cfg_fizz == 0 || cfg_buzz == 0 || cfg_max == 0);
            m_err = m_bad;
            m_hs  = m_valid && out_ready;
            if (m_acc && !m_bad) begin
                m_fizz = int'(cfg_fizz); m_buzz = int'(cfg_buzz); m_max = int'(cfg_max);
            end
            if (abort) begin
                m_st = M_IDLE; m_valid = 0;
            end else if (m_st == M_IDLE || m_st == M_DONE) begin
                if (start) begin
                    m_st = M_RUN; m_idx = 0; m_valid = 1;
`ifdef FIZZBUZZ_SEQ_STATS_EN
                    m_sf = 0; m_sb = 0; m_sfb = 0;
`endif
                end else if (m_st == M_DONE && m_acc) begin
                    m_st = M_IDLE;
                end
            end else if (m_st == M_RUN) begin
                if (m_hs) begin
`ifdef FIZZBUZZ_SEQ_STATS_EN
                    case (code_of(m_idx, m_fizz, m_buzz))
                        1: if (m_sf < 255) m_sf++;
                        2: if (m_sb < 255) m_sb++;
                        3: if (m_sfb < 255) m_sfb++;
                        default: ;
                    endcase
`endif
                    if (m_idx == m_max - 1) begin
                        m_st = M_DONE; m_valid = 0;
                    end else begin
                        m_idx++;
                        if (pause) begin m_st = M_PAUSE; m_valid = 0; end
                    end
                end
            end else if (m_st == M_PAUSE) begin
                if (!pause) begin m_st = M_RUN; m_valid = 1; end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_valid);
            check("busy", busy, (m_st == M_RUN || m_st == M_PAUSE));
            check("done", done, (m_st == M_DONE));
            check("cfg_ready", cfg_ready, (m_st == M_IDLE || m_st == M_DONE));
            check("cfg_err", cfg_err, m_err);
            check("stat_fizz", stat_fizz, m_sf);
            check("stat_buzz", stat_buzz, m_sb);
            check("stat_fb", stat_fb, m_sfb);
            if (m_valid) begin
                check("out_index", out_index, m_idx);
                check("out_code", out_code, code_of(m_idx, m_fizz, m_buzz));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic write_cfg(input int f, input int b, input int m);
        cfg_valid = 1'b1; cfg_fizz = W'(f); cfg_buzz = W'(b); cfg_max = W'(m);
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int limit, input int ready_mode, input bit pins, output int beats);
        beats = 0;
        got_codes.delete();
        for (int c = 0; c < limit && !done; c++) begin
            out_ready = (ready_mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (out_valid && out_ready) begin
                got_codes.push_back(int'(out_code));
                beats++;
                if (pins) begin
                    case (int'(out_index))
                        0:  check("pin_idx0", out_code, 3);
                        3:  check("pin_idx3", out_code, 1);
                        5:  check("pin_idx5", out_code, 2);
                        7:  check("pin_idx7", out_code, 0);
                        15: check("pin_idx15", out_code, 3);
                        default: ;
                    endcase
                end
            end
            cyc();
        end
        check("run_reached_done", done, 1);
        out_ready = 1'b0;
    endtask

    task automatic wait_index(input int idx, input int limit);
        int c = 0;
        out_ready = 1'b1;
        while (!(out_valid && int'(out_index) == idx) && c < limit) begin
            cyc();
            c++;
        end
        check("reach_index", (out_valid && int'(out_index) == idx), 1);
    endtask

    int beats;
    int exp_codes[6] = '{3, 0, 1, 2, 1, 0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        cyc();
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_code", out_code, 0);
        resetn = 1'b1;
        cyc();

        // Defaults: 100 beats, pinned codes, stats
        do_start();
        check("start_valid", out_valid, 1);
        check("start_busy", busy, 1);
        run_to_done(300, 0, 1'b1, beats);
        check("default_beats", beats, 100);
        check("default_done_busy", busy, 0);
`ifdef FIZZBUZZ_SEQ_STATS_EN
        check("default_stat_fizz", stat_fizz, 27);
        check("default_stat_buzz", stat_buzz, 13);
        check("default_stat_fb", stat_fb, 7);
`else
        check("stat_tied_fizz", stat_fizz, 0);
        check("stat_tied_fb", stat_fb, 0);
`endif

        // Rejected write keeps 3/5/100
        write_cfg(2, 0, 10);
        check("reject_err_pulse", cfg_err, 1);
        check("reject_to_idle", done, 0);
        cyc();
        check("reject_err_clear", cfg_err, 0);
        do_start();
        run_to_done(300, 0, 1'b1, beats);
        check("reject_beats", beats, 100);

        // 2/3/6 with out_ready 1,0,0 pattern
        write_cfg(2, 3, 6);
        check("accept_no_err", cfg_err, 0);
        do_start();
        run_to_done(100, 1, 1'b0, beats);
        check("b236_beats", beats, 6);
        for (int k = 0; k < 6 && k < got_codes.size(); k++)
            check("b236_code", got_codes[k], exp_codes[k]);

        // Pause from beat 4
        write_cfg(3, 5, 20);
        do_start();
        wait_index(4, 50);
        pause = 1'b1;
        cyc();
        check("pause_valid_low", out_valid, 0);
        check("pause_busy", busy, 1);
        repeat (4) begin
            cyc();
            check("pause_hold", out_valid, 0);
        end
        pause = 1'b0;
        cyc();
        check("resume_valid", out_valid, 1);
        check("resume_index", out_index, 5);
        run_to_done(100, 0, 1'b0, beats);
        check("pause_rest_beats", beats, 15);

        // Abort at index 40
        write_cfg(3, 5, 100);
        do_start();
        wait_index(40, 100);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_cfg_ready", cfg_ready, 1);
        do_start();
        check("restart_index", out_index, 0);
        check("restart_valid", out_valid, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        // Async reset mid-run restores defaults
        write_cfg(4, 7, 50);
        do_start();
        wait_index(20, 100);
        #2 resetn = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_index", out_index, 0);
        check("arst_cfg_ready", cfg_ready, 1);
        cyc();
        cyc();
        resetn = 1'b1;
        do_start();
        run_to_done(300, 0, 1'b1, beats);
        check("arst_default_beats", beats, 100);

        // max = 1
        write_cfg(4, 4, 1);
        do_start();
        check("max1_code", out_code, 3);
        out_ready = 1'b1;
        cyc();
        check("max1_done", done, 1);
        check("max1_valid", out_valid, 0);
        out_ready = 1'b0;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_fizz  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 9));
            cfg_buzz  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 9));
            cfg_max   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 24));
            start     = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 5) == 0) pause = ~pause;
            abort     = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        cfg_valid = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; out_ready = 1'b0;
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
